// File: rtl/master_in_port_if.sv
// master_in_port_if: bus bundle between the master core, the slave transmitter and master_in_port.
//   rx_request    : core asks for one read word
//   slave_ready   : slave has a word queued
//   rx_data       : serial line from the slave (idles low, start bit is high)
//   slave_tx_done : slave flags its last data bit
//   master_ready  : one-cycle request pulse to the slave
//   dataout       : last good word received
//   rx_valid      : dataout refreshed this cycle
//   rx_error      : timeout or framing error this cycle
//   rx_busy       : receiver is not idle
//   modport master: view of the receiver itself; modport slave: view of whoever drives it
interface master_in_port_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  rx_request;
    logic                  slave_ready;
    logic                  rx_data;
    logic                  slave_tx_done;
    logic                  master_ready;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  rx_valid;
    logic                  rx_error;
    logic                  rx_busy;
    modport master (
        input  rx_request, slave_ready, rx_data, slave_tx_done,
        output master_ready, dataout, rx_valid, rx_error, rx_busy
    );
    modport slave (
        output rx_request, slave_ready, rx_data, slave_tx_done,
        input  master_ready, dataout, rx_valid, rx_error, rx_busy
    );
endinterface

// File: rtl/master_in_port.sv
// master_in_port: master-side serial receiver that requests a word, waits for a start bit and shifts in DATA_WIDTH bits LSB-first.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : master_in_port_if.master (request/serial inputs, word/strobe/busy outputs)
// Every output is a flop loaded from the next-state decode, so strobes line up with the state they describe.
module master_in_port #(
    parameter int DATA_WIDTH = 12,
    parameter int TIMEOUT    = 16
) (
    input logic             clk,
    input logic             reset,
    master_in_port_if.master bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_START, RECEIVE, DONE} state_t;
    state_t                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  master_ready_q, rx_valid_q, rx_error_q, rx_busy_q;
    logic                  last_bit;
    assign last_bit = bit_cnt_q == BW'(DATA_WIDTH - 1);
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        err_d     = err_q;
        case (state_q)
            IDLE: state_d = (bus.rx_request && bus.slave_ready) ? REQ : IDLE;
            REQ: begin
                timer_d = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (bus.rx_data) begin
                    bit_cnt_d = '0;
                    state_d   = RECEIVE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RECEIVE: begin
                shift_d[bit_cnt_q] = bus.rx_data;
                // the done flag must coincide with the final bit: early or missing both mean a broken frame
                if (last_bit) begin
                    err_d   = ~bus.slave_tx_done;
                    state_d = DONE;
                end else if (bus.slave_tx_done) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            timer_q        <= '0;
            shift_q        <= '0;
            err_q          <= 1'b0;
            dataout_q      <= '0;
            master_ready_q <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_error_q     <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            timer_q        <= timer_d;
            shift_q        <= shift_d;
            err_q          <= err_d;
            master_ready_q <= state_d == REQ;
            rx_busy_q      <= state_d != IDLE;
            rx_valid_q     <= state_d == DONE && !err_d;
            rx_error_q     <= state_d == DONE && err_d;
            // shift_d already holds the final bit, so the word is published together with rx_valid
            if (state_d == DONE && !err_d)
                dataout_q <= shift_d;
        end
    end
    assign bus.master_ready = master_ready_q;
    assign bus.dataout      = dataout_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_error     = rx_error_q;
    assign bus.rx_busy      = rx_busy_q;
endmodule

// File: tb/tb_master_in_port.sv
// tb_master_in_port: randomized and directed frames checked cycle by cycle against a transaction-level timing model.
module tb_master_in_port;
    localparam int DW = 12;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset;
    int n_assert = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_dout = '0;
    master_in_port_if #(.DATA_WIDTH(DW)) bus ();
    master_in_port #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    // observed vector: {master_ready, rx_busy, rx_valid, rx_error, dataout}
    task automatic check(input string tag, input int c, input logic [DW+3:0] exp);
        logic [DW+3:0] obs;
        obs = {bus.master_ready, bus.rx_busy, bus.rx_valid, bus.rx_error, bus.dataout};
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask
    // Cycle 0 is the master_ready cycle; request is presented in cycle -1.
    // Start bit in cycle 1+d (d<TO), data bit i in cycle 2+d+i, done flag on bit p (p>=DW: never).
    task automatic run_frame(input string tag, input logic [DW-1:0] data, input int d, input int p,
                             input bit start, input int abort_c);
        int  last;
        bit  err;
        if (!start) begin
            last = TO + 1;
            err  = 1'b1;
        end else if (p < DW - 1) begin
            last = 3 + d + p;
            err  = 1'b1;
        end else begin
            last = 2 + d + DW;
            err  = (p != DW - 1);
        end
        @(negedge clk);
        bus.rx_request    = 1'b1;
        bus.slave_ready   = 1'b1;
        bus.rx_data       = 1'b0;
        bus.slave_tx_done = 1'b0;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                reset = 1'b0;
                #1;
                exp_dout = '0;
                check({tag, "_rst"}, c, '0);
                @(negedge clk);
                check({tag, "_rst_hold"}, c + 1, '0);
                bus.rx_data       = 1'b0;
                bus.slave_tx_done = 1'b0;
                reset             = 1'b1;
                return;
            end
            check(tag, c, {c == 0, c <= last, c == last && !err, c == last && err,
                           (c >= last && !err) ? data : exp_dout});
            bus.rx_request  = 1'b0;
            bus.slave_ready = 1'($urandom);
            if (c >= 1 && c < last) begin
                bus.rx_data       = start && (c == 1 + d || (c >= 2 + d && data[c-2-d]));
                bus.slave_tx_done = start && c == 2 + d + p;
            end else begin
                bus.rx_data       = 1'($urandom);
                bus.slave_tx_done = 1'($urandom);
            end
        end
        if (!err) exp_dout = data;
    endtask
    initial begin
        reset             = 1'b0;
        bus.rx_request    = 1'b0;
        bus.slave_ready   = 1'b0;
        bus.rx_data       = 1'b0;
        bus.slave_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", -1, '0);
        reset = 1'b1;
        run_frame("nominal", 12'h0CC, 0, DW - 1, 1'b1, -1);
        run_frame("start_delay", 12'hA5F, 4, DW - 1, 1'b1, -1);
        run_frame("timeout", 12'h123, 0, DW - 1, 1'b0, -1);
        run_frame("last_start", 12'h3C9, TO - 1, DW - 1, 1'b1, -1);
        run_frame("early_done", 12'h5A5, 0, 6, 1'b1, -1);
        run_frame("missing_done", 12'h0F0, 2, DW, 1'b1, -1);
        run_frame("reset_mid", 12'h0CC, 0, DW - 1, 1'b1, 6);
        run_frame("after_reset", 12'hFFF, 0, DW - 1, 1'b1, -1);
        @(negedge clk);
        bus.rx_request  = 1'b1;
        bus.slave_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gating", i, {4'b0000, exp_dout});
        end
        run_frame("gate_release", DW'($urandom), 0, DW - 1, 1'b1, -1);
        for (int i = 0; i < 40; i++) begin
            int m;
            m = $urandom_range(0, 9);
            case (m)
                6: run_frame("rand_early", DW'($urandom), $urandom_range(0, 6), $urandom_range(0, DW - 2), 1'b1, -1);
                7: run_frame("rand_missing", DW'($urandom), $urandom_range(0, 6), DW, 1'b1, -1);
                8: run_frame("rand_timeout", DW'($urandom), 0, DW - 1, 1'b0, -1);
                9: run_frame("rand_late", DW'($urandom), $urandom_range(7, TO - 1), DW - 1, 1'b1, -1);
                default: run_frame("rand_good", DW'($urandom), $urandom_range(0, 6), DW - 1, 1'b1, -1);
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/master_in_port.md
# master_in_port

Master-side serial receiver that sits directly downstream of `slave_out_port` on the bus read path. It requests a word from the slave with a one-cycle `master_ready` pulse, detects the start bit on the serial line, and shifts in `DATA_WIDTH` bits LSB-first. It then presents the assembled word to the master core with a one-cycle valid strobe, or reports a framing/timeout error.

## Interface
- `DATA_WIDTH`, 12: serial payload width in bits.
- `TIMEOUT`, 16: maximum number of cycles to wait for the start bit after `master_ready`; must be ≥2.

- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rx_request` input 1: master core requests one read word; level-sensitive, sampled only in IDLE.
- `slave_ready` input 1: slave has data queued and can transmit.
- `rx_data` input 1: serial line from the slave's `tx_data`.
- `slave_tx_done` input 1: slave marks its last data bit, asserted in the same cycle as that bit.
- `master_ready` output 1: one-cycle request pulse to the slave.
- `dataout` output DATA_WIDTH: last successfully received word; holds its value between transfers.
- `rx_valid` output 1: one-cycle strobe; `dataout` is new this cycle.
- `rx_error` output 1: one-cycle strobe on timeout or framing error.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT_START, RECEIVE, DONE.
- **IDLE**
  - If `rx_request`=1 and `slave_ready`=1, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `master_ready`=1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT_START.
- **WAIT_START**
  - The line idles low; the start bit is `rx_data`=1.
  - On a start bit: clear `bit_cnt`, go to RECEIVE.
  - Otherwise increment the timer. When the timer reaches TIMEOUT-1 with no start bit, set `err` and go to DONE.
- **RECEIVE**
  - Each cycle: `shift[bit_cnt] <= rx_data` (LSB first), then `bit_cnt++`.
  - When `bit_cnt`=DATA_WIDTH-1, capture the last bit. `slave_tx_done` must be 1 in this cycle; otherwise set `err`. Go to DONE.
  - If `slave_tx_done`=1 while `bit_cnt`<DATA_WIDTH-1 (early done), set `err` and go to DONE immediately.
- **DONE** (one cycle)
  - If `err`=0: `dataout<=shift` and `rx_valid`=1.
  - If `err`=1: `rx_error`=1 and `dataout` is unchanged.
  - Clear `err` and go to IDLE.
- `bit_cnt` width is clog2(DATA_WIDTH); the timer width is clog2(TIMEOUT). Neither counter wraps; both are cleared on every entry to their state.
- `rx_request` or `slave_ready` dropping after IDLE has no effect; the transfer runs to DONE.
- `rx_data` is ignored outside WAIT_START and RECEIVE.
- `rx_valid` and `rx_error` are never high in the same cycle.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE.
  - `master_ready`, `rx_valid`, `rx_error`, `rx_busy` go to 0.
  - `dataout`, `shift`, counters and `err` go to 0.
- Reset mid-frame aborts the transfer; no `rx_valid` or `rx_error` is emitted.
- Edge numbering: request seen at edge 0.
  - Edge 1: `master_ready` goes high for 1 cycle.
  - Earliest start bit is sampled at edge 2.
  - Data bits are sampled at edges 3 … 2+DATA_WIDTH.
  - `rx_valid` is high for the cycle after edge 3+DATA_WIDTH-1.
- Minimum request-to-valid latency is DATA_WIDTH+3 cycles (15 with defaults).
- `rx_busy` rises 1 cycle after the request is accepted and falls when DONE exits.
- Back-to-back transfers: after DONE, at least one IDLE cycle before the next REQ. `master_ready` pulses are therefore never closer than DATA_WIDTH+4 cycles.
- Timeout: with no start bit, `rx_error` pulses TIMEOUT+1 cycles after `master_ready`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Nominal word:** `slave_ready`=1, `rx_request` pulsed; slave sends start bit then 12'h0CC LSB-first (0,0,1,1,0,0,1,1,0,0,0,0) with `slave_tx_done` on bit 11.
  - Required: exactly one `master_ready` pulse, `rx_valid` for 1 cycle 15 cycles after the request, `dataout`=12'h0CC, `rx_error`=0.
- **Start delay:** as nominal but with the start bit 5 cycles after `master_ready`, data 12'hA5F.
  - Required: `dataout`=12'hA5F; `rx_valid` is 4 cycles later than in the nominal case.
- **Timeout:** no start bit ever.
  - Required: `rx_error` pulses TIMEOUT+1=17 cycles after `master_ready`, `dataout` keeps its old value, `rx_busy` falls, FSM returns to IDLE.
- **Framing errors:** case 1, `slave_tx_done` asserted on bit 6; case 2, `slave_tx_done` missing on bit 11.
  - Required: `rx_error` pulses in both cases, `rx_valid` stays 0, `dataout` is unchanged.
- **Reset mid-frame:** `reset`=0 during bit 4, released, then a new nominal transfer of 12'hFFF.
  - Required: all outputs 0 immediately on reset with no strobe; the second transfer gives `dataout`=12'hFFF.
- **Gating:** `rx_request`=1 with `slave_ready`=0 for 20 cycles.
  - Required: no `master_ready`, `rx_busy`=0.
  - When `slave_ready` rises, `master_ready` pulses on the next edge.
